red_pitaya_iir_cascade: RTL and testbench



---
 rtl/red_pitaya_iir_cascade.sv | 162 ++++++++++++++++
 tb/tb_red_pitaya_iir_cascade.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_iir_cascade.sv
// Cascade of first-order IIR low/high-pass stages with bypass, bumpless
// reconfiguration, settle tracking and a sticky highpass saturation flag.

module red_pitaya_iir_stage #(
    parameter int SHIFTBITS = 4,
    parameter int IW        = 16,
    parameter int MINSHIFT  = 2,
    parameter int MAXSHIFT  = 17
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [7:0]           i_cfg,
    input  logic signed [IW-1:0] i_x,
    output logic signed [IW-1:0] o_out,
    output logic                 o_clip,
    output logic                 o_idle_next
);
    localparam int ACCW = IW + MAXSHIFT;
    localparam int CNTW = MAXSHIFT + 3;

    logic [7:0]             r_cfg;
    logic signed [ACCW-1:0] r_acc;
    logic signed [IW-1:0]   r_out;
    logic [CNTW-1:0]        r_cnt;

    logic [7:0]             w_seff_cur;
    logic [7:0]             w_seff_new;
    logic                   w_change;
    logic signed [ACCW-1:0] w_xs;
    logic signed [ACCW:0]   w_diff;
    logic signed [ACCW:0]   w_step;
    logic signed [ACCW-1:0] w_acc_next;
    logic signed [IW-1:0]   w_lp;
    logic signed [IW:0]     w_hpd;
    logic [CNTW-1:0]        w_cnt_reload;
    logic signed [ACCW-1:0] w_acc_d;
    logic signed [IW-1:0]   w_out_d;
    logic [CNTW-1:0]        w_cnt_d;
    logic                   w_clip;

    assign w_seff_cur   = 8'(r_cfg[SHIFTBITS-1:0]) + 8'(MINSHIFT);
    assign w_seff_new   = 8'(i_cfg[SHIFTBITS-1:0]) + 8'(MINSHIFT);
    assign w_change     = (i_cfg != r_cfg);
    assign w_cnt_reload = CNTW'(4) << w_seff_new;

    // Accumulator holds the lowpass state scaled by 2^MAXSHIFT.
    assign w_xs       = {i_x, {MAXSHIFT{1'b0}}};
    assign w_diff     = {w_xs[ACCW-1], w_xs} - {r_acc[ACCW-1], r_acc};
    assign w_step     = w_diff >>> w_seff_cur;
    assign w_acc_next = r_acc + ACCW'(w_step);
    assign w_lp       = w_acc_next[ACCW-1:MAXSHIFT];
    assign w_hpd      = {i_x[IW-1], i_x} - {w_lp[IW-1], w_lp};

    always_comb begin
        w_acc_d = w_xs;
        w_out_d = i_x;
        w_clip  = 1'b0;
        w_cnt_d = (r_cnt != '0) ? r_cnt - CNTW'(1) : '0;
        if (w_change) begin
            // Preload from the current input so enabling is bumpless.
            w_cnt_d = i_cfg[7] ? w_cnt_reload : '0;
            if (i_cfg[7] && i_cfg[6])
                w_out_d = '0;
        end else if (r_cfg[7]) begin
            w_acc_d = w_acc_next;
            if (r_cfg[6]) begin
                w_clip  = (w_hpd[IW] != w_hpd[IW-1]);
                w_out_d = w_clip ? {w_hpd[IW], {(IW-1){~w_hpd[IW]}}} : w_hpd[IW-1:0];
            end else begin
                w_out_d = w_lp;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_cfg <= '0;
            r_acc <= '0;
            r_out <= '0;
            r_cnt <= '0;
        end else begin
            r_cfg <= i_cfg;
            r_acc <= w_acc_d;
            r_out <= w_out_d;
            r_cnt <= w_cnt_d;
        end
    end

    assign o_out       = r_out;
    assign o_clip      = w_clip;
    assign o_idle_next = (w_cnt_d == '0);
endmodule

module red_pitaya_iir_cascade #(
    parameter int STAGES          = 4,
    parameter int SHIFTBITS       = 4,
    parameter int SIGNALBITS      = 14,
    parameter int EXTRAOUTPUTBITS = 2,
    parameter int MINSHIFT        = 2
) (
    input  logic                                        clk_i,
    input  logic                                        rstn_i,
    input  logic [8*STAGES-1:0]                         set_filter,
    input  logic signed [SIGNALBITS-1:0]                dat_i,
    output logic signed [SIGNALBITS+EXTRAOUTPUTBITS-1:0] dat_o,
    output logic                                        settled_o,
    output logic                                        sat_o,
    input  logic                                        sat_clr_i
);
    localparam int IW       = SIGNALBITS + EXTRAOUTPUTBITS;
    localparam int MAXSHIFT = (1 << SHIFTBITS) - 1 + MINSHIFT;

    logic [STAGES-1:0][IW-1:0] w_x;
    logic [STAGES-1:0][IW-1:0] w_out;
    logic [STAGES-1:0]         w_clip;
    logic [STAGES-1:0]         w_idle;
    logic                      r_settled;
    logic                      r_sat;

    assign w_x[0] = IW'(dat_i) << EXTRAOUTPUTBITS;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            if (k > 0) begin : g_chain
                assign w_x[k] = w_out[k-1];
            end
            red_pitaya_iir_stage #(
                .SHIFTBITS (SHIFTBITS),
                .IW        (IW),
                .MINSHIFT  (MINSHIFT),
                .MAXSHIFT  (MAXSHIFT)
            ) u_stage (
                .clk_i       (clk_i),
                .rstn_i      (rstn_i),
                .i_cfg       (set_filter[8*k +: 8]),
                .i_x         (w_x[k]),
                .o_out       (w_out[k]),
                .o_clip      (w_clip[k]),
                .o_idle_next (w_idle[k])
            );
        end
    endgenerate

    // A clip in the same cycle as a clear wins.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_settled <= 1'b1;
            r_sat     <= 1'b0;
        end else begin
            r_settled <= &w_idle;
            if (|w_clip)
                r_sat <= 1'b1;
            else if (sat_clr_i)
                r_sat <= 1'b0;
        end
    end

    assign dat_o     = w_out[STAGES-1];
    assign settled_o = r_settled;
    assign sat_o     = r_sat;
endmodule

// File: tb/tb_red_pitaya_iir_cascade.sv
// Bench for red_pitaya_iir_cascade: table vectors, dat_o scoreboard, and
// hand sequences for saturation, settle timing and mid-run reset.

module tb_red_pitaya_iir_cascade;
    logic               clk_i = 1'b0;
    logic               rstn_i;
    logic [31:0]        set_filter;
    logic signed [13:0] dat_i;
    logic signed [15:0] dat_o;
    logic               settled_o;
    logic               sat_o;
    logic               sat_clr_i;

    red_pitaya_iir_cascade #(
        .STAGES(4), .SHIFTBITS(4), .SIGNALBITS(14), .EXTRAOUTPUTBITS(2), .MINSHIFT(2)
    ) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .set_filter (set_filter),
        .dat_i      (dat_i),
        .dat_o      (dat_o),
        .settled_o  (settled_o),
        .sat_o      (sat_o),
        .sat_clr_i  (sat_clr_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int due; int exp; } sb_t;
    typedef struct { int din; int exp; } vec_t;

    sb_t  q[$];
    vec_t lp_tab[7];
    vec_t hp_tab[7];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Scoreboard: compare dat_o on the falling edge when an entry is due.
    always @(negedge clk_i) begin
        sb_t e;
        int  got;
        if (q.size() > 0 && q[0].due <= cyc) begin
            e   = q.pop_front();
            got = dat_o;
            chk("dat_o", got, e.exp);
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Input sampled at the next edge; dat_o reflects it STAGES edges later.
    task automatic drive(input int din, input int exp, input bit push);
        dat_i = 14'(din);
        if (push) q.push_back(sb_t'{cyc + 4, exp});
        step();
    endtask

    task automatic reset_dut();
        rstn_i = 1'b0;
        q.delete();
        step();
        rstn_i = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() > 0; i++) step();
        chk("sb_drain", q.size(), 0);
    endtask

    initial begin
        int lpv[7];
        int nlow;
        lpv = '{4096, 7168, 9472, 11200, 12496, 13468, 14197};
        for (int i = 0; i < 7; i++) begin
            lp_tab[i] = '{din: 4096, exp: lpv[i]};
            hp_tab[i] = '{din: 4096, exp: 16384 - lpv[i]};
        end

        rstn_i = 1'b0; set_filter = '0; dat_i = '0; sat_clr_i = 1'b0;
        step(); step();
        chk("rst_dat_o", dat_o, 0);
        chk("rst_settled", settled_o, 1);
        chk("rst_sat", sat_o, 0);
        rstn_i = 1'b1;

        // Bypass: impulse of 100 appears as 400 four cycles later.
        nlow = 0;
        for (int i = 0; i < 12; i++) begin
            drive((i == 2) ? 100 : 0, (i == 2) ? 400 : 0, 1'b1);
            if (!settled_o) nlow++;
        end
        drain();
        chk("bypass_settled", nlow, 0);

        // Lowpass step on stage 0.
        reset_dut();
        set_filter = 32'h0000_0080;
        for (int i = 0; i < 20; i++) drive(0, 0, 1'b1);
        for (int i = 0; i < 7; i++) drive(lp_tab[i].din, lp_tab[i].exp, 1'b1);
        drain();

        // Highpass step on stage 0.
        reset_dut();
        set_filter = 32'h0000_00C0;
        for (int i = 0; i < 20; i++) drive(0, 0, 1'b1);
        for (int i = 0; i < 7; i++) drive(hp_tab[i].din, hp_tab[i].exp, 1'b1);
        drain();
        chk("hp_no_sat", sat_o, 0);

        // Saturation with slow highpass, clear-vs-clip priority.
        reset_dut();
        set_filter = 32'h0000_00CF;
        for (int i = 0; i < 20; i++) drive(8191, 0, 1'b1);
        chk("sat_pre", sat_o, 0);
        drive(-8192, -32768, 1'b1);
        chk("sat_set", sat_o, 1);
        sat_clr_i = 1'b1;
        drive(-8192, -32768, 1'b1);
        sat_clr_i = 1'b0;
        chk("sat_clip_wins", sat_o, 1);
        drive(-8192, -32768, 1'b1);
        drive(8191, 0, 1'b0);
        chk("sat_hold", sat_o, 1);
        sat_clr_i = 1'b1;
        drive(8191, 0, 1'b0);
        sat_clr_i = 1'b0;
        chk("sat_cleared", sat_o, 0);
        for (int i = 0; i < 4; i++) drive(8191, 0, 1'b0);
        drain();

        // Reconfigure stage 2 under steady input: bumpless, 128-cycle settle.
        reset_dut();
        set_filter = '0;
        for (int i = 0; i < 8; i++) drive(1000, 4000, 1'b1);
        chk("settle_idle", settled_o, 1);
        set_filter = 32'h0083_0000;
        nlow = 0;
        for (int i = 0; i < 300; i++) begin
            drive(1000, 4000, 1'b1);
            if (settled_o) break;
            nlow++;
        end
        chk("settle_len", nlow, 128);
        set_filter = 32'h00A3_0000;
        nlow = 0;
        for (int i = 0; i < 50; i++) begin
            drive(1000, 4000, 1'b1);
            if (!settled_o) nlow++;
        end
        chk("settle_first50", nlow, 50);
        set_filter = 32'h0083_0000;
        nlow = 0;
        for (int i = 0; i < 300; i++) begin
            drive(1000, 4000, 1'b1);
            if (settled_o) break;
            nlow++;
        end
        chk("settle_restart", nlow, 128);
        drain();

        // Reset in the middle of a lowpass step.
        reset_dut();
        set_filter = 32'h0000_0080;
        for (int i = 0; i < 20; i++) drive(0, 0, 1'b1);
        for (int i = 0; i < 6; i++) drive(4096, 0, 1'b0);
        chk("pre_reset_dat", dat_o, 9472);
        rstn_i = 1'b0;
        q.delete();
        step();
        chk("mid_rst_dat_o", dat_o, 0);
        chk("mid_rst_settled", settled_o, 1);
        chk("mid_rst_sat", sat_o, 0);
        rstn_i = 1'b1;
        step();
        chk("post_rst_redetect", settled_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
